branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Decode-stage consumer of the branch forwarding selects `fub_cs_1`/`fub_cs_2`.
- Selects the final branch operands from the register file, the MEM-stage ALU result or the MEM-stage read data, and evaluates conditional branches, JAL and JALR in ID.
- Detects EX-stage producer hazards that forwarding cannot cover and stalls on them.
- On a taken branch, issues a registered PC redirect and an IF/ID flush. Policy is predict-not-taken.
- Keeps saturating branch statistics.

Parameters:
- XLEN, 32, datapath and PC width.
- CNT_W, 16, width of the statistics counters.
- STALL_LIMIT, 4, consecutive stall cycles before `hazard_timeout` is set.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- id_is_jal  in  1  JAL.
- id_is_jalr  in  1  JALR.
- id_funct3  in  3  branch condition.
- id_pc  in  XLEN  PC of the ID instruction.
- id_imm  in  XLEN  sign-extended immediate.
- rs1, rs2  in  5  source register indices.
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data.
- fub_cs_1, fub_cs_2  in  2  forward selects: 00 = RF, 10 = MEM ALU result, 01 = MEM read data, 11 = treated as RF.
- mem_alu_result  in  XLEN  MEM-stage ALU result.
- mem_read_data  in  XLEN  MEM-stage load data.
- ex_rd  in  5  EX-stage destination register.
- ex_register_write_enable  in  1  EX-stage instruction writes `ex_rd`.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- redirect_valid  out  1  one-cycle redirect pulse (registered).
- redirect_pc  out  XLEN  redirect target (registered).
- flush_if_id  out  1  squash IF/ID contents (registered; equals `redirect_valid`).
- hazard_timeout  out  1  sticky flag: stall count reached STALL_LIMIT.
- branch_count  out  CNT_W  resolved control instructions, saturating.
- taken_count  out  CNT_W  taken control instructions, saturating.

Behaviour:
- Reset (async, rst=1): FSM enters RUN. The following all go to 0: `redirect_valid`, `flush_if_id`, `redirect_pc`, `hazard_timeout`, `branch_count`, `taken_count`, stall counter. A reset mid-stall or mid-flush abandons it; `stall` drops while rst=1.
- ctrl = `id_valid` & (`id_is_branch` | `id_is_jal` | `id_is_jalr`).
- Operand select:
  - rsN == 0 forces the operand to 0, regardless of `fub_cs_N` or RF data.
  - Otherwise the operand is chosen by the `fub_cs_N` code above.
- EX hazard:
  - Applies to ctrl (excluding JAL) with `ex_register_write_enable`=1, `ex_rd`!=0, and `ex_rd` == rs1, or `ex_rd` == rs2 for branches only.
  - JALR checks rs1 only; JAL checks nothing.
- `stall` = state==RUN & ctrl & EX hazard. No resolution happens in a stalled cycle.
- Stall counter:
  - Increments each consecutive stall cycle and clears on a non-stall cycle.
  - Reaching STALL_LIMIT sets `hazard_timeout`, which clears only on rst.
- FSM RUN:
  - Resolution happens when ctrl & !stall.
  - taken = JAL | JALR | (branch & cond). Conditions by `id_funct3`:
    - 000 eq, 001 ne, 100 signed lt, 101 signed ge.
    - 110 unsigned lt, 111 unsigned ge.
    - 010 and 011 never taken.
  - Targets:
    - branch/JAL: `id_pc` + `id_imm`, modulo 2^XLEN.
    - JALR: (op1 + `id_imm`) with bit 0 cleared.
  - On taken: register the target into `redirect_pc`, and next cycle assert `redirect_valid` = `flush_if_id` = 1, state → FLUSH.
  - Not taken: stay in RUN with no outputs.
- FSM FLUSH (exactly one cycle):
  - The ID contents are wrong-path. No resolution, no stall, no counting.
  - Returns to RUN. `redirect_valid`/`flush_if_id` deassert the following cycle.
- Counters:
  - `branch_count` increments once per resolution; `taken_count` once per taken resolution.
  - Both saturate at all-ones.
  - A stall followed by a resolution counts once.
- Latency: resolution cycle N → `redirect_valid` in cycle N+1. Back-to-back taken branches are impossible because of FLUSH.

Decomposition:
- Shared package:
  - forward select codes FWD_RF = 2'b00, FWD_MEM_READ = 2'b01, FWD_MEM_ALU = 2'b10;
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - FSM state encoding RUN/FLUSH.
- One natural sub-module, `branch_compare`: purely combinational operand compare plus funct3 decode producing `cond`.

Test Plan:
- BEQ, rs1=x5, rs2=x6, RF data both 0x10, fub_cs=00, `id_pc`=0x100, imm=0x20 → `redirect_valid`=1 and `redirect_pc`=0x120 next cycle; `taken_count`=1; FLUSH for 1 cycle.
- BLT with RF 0xFFFFFFFF vs 1 → taken. Same operands with BLTU → not taken, no redirect, `branch_count`=2.
- BNE, rs1=x3, `fub_cs_1`=10, `mem_alu_result`=7, rf=0, rs2 data 0 → taken. Same with `fub_cs_1`=01 and `mem_read_data`=0 → not taken.
- BEQ with rs1=x4, `ex_rd`=4, `ex_register_write_enable`=1 → `stall`=1 that cycle with no resolution. Next cycle EX clear and `fub_cs_1`=10 → resolves and `stall`=0.
- JALR with rs1=x0 and `ex_rd`=0 writing → no stall, op1=0, imm=0x41 → `redirect_pc`=0x40.
- Hold the hazard for 4 cycles → `hazard_timeout`=1 and it stays set. Assert rst mid-FLUSH → `redirect_valid`=0 immediately, state RUN, counters 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg
// Shared definitions for the decode-stage branch resolution slice.
//   - Forwarding select codes driven by the forwarding unit (fub_cs_1/2).
//   - funct3 encodings of the RV32 conditional branches.
//   - Resolution FSM state encoding.
package branch_resolve_unit_pkg;

  // Forwarding select codes; 2'b11 is not produced normally and falls back to RF
  localparam logic [1:0] FWD_RF       = 2'b00;
  localparam logic [1:0] FWD_MEM_READ = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU  = 2'b10;

  // Conditional branch funct3 encodings
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // RUN resolves control instructions; FLUSH is the single wrong-path cycle
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// branch_compare
// Purely combinational branch condition evaluation.
// Ports:
//   op1_i, op2_i  in  XLEN  resolved branch operands
//   funct3_i      in  3     branch condition encoding
//   cond_o        out 1     condition holds (0 for reserved encodings 010/011)
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [2:0]      funct3_i,
  output logic            cond_o
);

  always_comb begin
    cond_o = 1'b0;
    unique case (funct3_i)
      BEQ:     cond_o = (op1_i == op2_i);
      BNE:     cond_o = (op1_i != op2_i);
      BLT:     cond_o = ($signed(op1_i) <  $signed(op2_i));
      BGE:     cond_o = ($signed(op1_i) >= $signed(op2_i));
      BLTU:    cond_o = (op1_i <  op2_i);
      BGEU:    cond_o = (op1_i >= op2_i);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves conditional branches, JAL and JALR in the decode stage using
// forwarded operands, stalls on EX-stage producers that forwarding cannot
// reach yet, and issues a registered PC redirect plus IF/ID flush on taken
// control flow (predict-not-taken). Also keeps saturating statistics.
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   id_*                         decoded ID-stage instruction fields
//   rs1, rs2, rf_rs1/2_data      source indices and register file data
//   fub_cs_1, fub_cs_2           forwarding selects per operand
//   mem_alu_result/read_data     MEM-stage forwarding sources
//   ex_rd, ex_register_write_enable  EX-stage producer for hazard detection
//   stall                        combinational hold of PC and IF/ID
//   redirect_valid/redirect_pc   registered one-cycle redirect
//   flush_if_id                  registered IF/ID squash (same as redirect_valid)
//   hazard_timeout               sticky: stall run reached STALL_LIMIT
//   branch_count, taken_count    saturating resolution statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic [2:0]       id_funct3,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic [1:0]       fub_cs_1,
  input  logic [1:0]       fub_cs_2,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_register_write_enable,
  output logic             stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             hazard_timeout,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_LIMIT);

  state_e           state_q;
  logic             redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] taken_count_q;
  logic [SCW-1:0]   stall_cnt_q;
  logic             hazard_timeout_q;

  logic            ctrl;
  logic            ex_hazard;
  logic            resolve;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] target;

  assign ctrl = id_valid & (id_is_branch | id_is_jal | id_is_jalr);

  // x0 always reads as zero, whatever the forwarding unit claims
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      idx,
    input logic [1:0]      cs,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] rdata
  );
    logic [XLEN-1:0] res;
    if (idx == 5'd0)             res = '0;
    else if (cs == FWD_MEM_ALU)  res = alu;
    else if (cs == FWD_MEM_READ) res = rdata;
    else                         res = rf;
    return res;
  endfunction

  assign op1 = sel_operand(rs1, fub_cs_1, rf_rs1_data, mem_alu_result, mem_read_data);
  assign op2 = sel_operand(rs2, fub_cs_2, rf_rs2_data, mem_alu_result, mem_read_data);

  // EX results are not forwardable into ID yet; JALR only reads rs1, JAL nothing
  assign ex_hazard = ex_register_write_enable && (ex_rd != 5'd0) &&
                     (((id_is_branch || id_is_jalr) && (ex_rd == rs1)) ||
                      (id_is_branch && (ex_rd == rs2)));

  // Gated by rst so a stall request is withdrawn as soon as reset asserts
  assign stall   = !rst && (state_q == RUN) && ctrl && ex_hazard;
  assign resolve = (state_q == RUN) && ctrl && !stall;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .op1_i    (op1),
    .op2_i    (op2),
    .funct3_i (id_funct3),
    .cond_o   (cond)
  );

  assign taken = id_is_jal || id_is_jalr || (id_is_branch && cond);

  always_comb begin
    target = id_pc + id_imm;
    if (id_is_jalr && !id_is_jal) begin
      target = (op1 + id_imm) & ~XLEN'(1);
    end
  end

  // Resolution FSM: a taken resolution registers the redirect and spends the
  // next cycle in FLUSH, where the ID contents are wrong-path and ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_count_q   <= '0;
      taken_count_q    <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          redirect_valid_q <= 1'b0;
          if (resolve) begin
            if (branch_count_q != '1) branch_count_q <= branch_count_q + 1'b1;
            if (taken) begin
              if (taken_count_q != '1) taken_count_q <= taken_count_q + 1'b1;
              redirect_pc_q    <= target;
              redirect_valid_q <= 1'b1;
              state_q          <= FLUSH;
            end
          end
        end
        FLUSH: begin
          redirect_valid_q <= 1'b0;
          state_q          <= RUN;
        end
        default: begin
          redirect_valid_q <= 1'b0;
          state_q          <= RUN;
        end
      endcase
    end
  end

  // Consecutive stall run length; the timeout flag latches once the run
  // reaches STALL_LIMIT and is only cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q      <= '0;
      hazard_timeout_q <= 1'b0;
    end else if (stall) begin
      if (stall_cnt_q != STALL_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (stall_cnt_q >= STALL_MAX - 1'b1) hazard_timeout_q <= 1'b1;
    end else begin
      stall_cnt_q <= '0;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush_if_id    = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_count   = branch_count_q;
  assign taken_count    = taken_count_q;
  assign hazard_timeout = hazard_timeout_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Directed vector table for single-instruction resolution plus hand-written
// sequences for stall-then-resolve, hazard timeout and reset during FLUSH.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        idValid, isBr, isJal, isJalr;
  logic [2:0]  funct3;
  logic [31:0] idPc, idImm;
  logic [4:0]  rs1, rs2;
  logic [31:0] rf1, rf2;
  logic [1:0]  cs1, cs2;
  logic [31:0] memAlu, memRead;
  logic [4:0]  exRd;
  logic        exWe;
  logic        stall, redirectValid, flushIfId, hazardTimeout;
  logic [31:0] redirectPc;
  logic [15:0] branchCount, takenCount;

  int checks = 0;
  int errors = 0;
  int expBc  = 0;
  int expTc  = 0;

  branch_resolve_unit dut (
    .clk                      (clk),
    .rst                      (rst),
    .id_valid                 (idValid),
    .id_is_branch             (isBr),
    .id_is_jal                (isJal),
    .id_is_jalr               (isJalr),
    .id_funct3                (funct3),
    .id_pc                    (idPc),
    .id_imm                   (idImm),
    .rs1                      (rs1),
    .rs2                      (rs2),
    .rf_rs1_data              (rf1),
    .rf_rs2_data              (rf2),
    .fub_cs_1                 (cs1),
    .fub_cs_2                 (cs2),
    .mem_alu_result           (memAlu),
    .mem_read_data            (memRead),
    .ex_rd                    (exRd),
    .ex_register_write_enable (exWe),
    .stall                    (stall),
    .redirect_valid           (redirectValid),
    .redirect_pc              (redirectPc),
    .flush_if_id              (flushIfId),
    .hazard_timeout           (hazardTimeout),
    .branch_count             (branchCount),
    .taken_count              (takenCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] valid, br, jal, jalr, f3, pc, imm, r1, r2, d1, d2, c1, c2, alu, rdat, erd, ewe;
    bit [31:0] eStall, eTaken, ePc, eBc, eTc;
  } vec_t;

  vec_t vecs[17];

  task automatic applyStimulus(input vec_t v);
    idValid = v.valid[0]; isBr = v.br[0]; isJal = v.jal[0]; isJalr = v.jalr[0];
    funct3 = v.f3[2:0]; idPc = v.pc; idImm = v.imm;
    rs1 = v.r1[4:0]; rs2 = v.r2[4:0]; rf1 = v.d1; rf2 = v.d2;
    cs1 = v.c1[1:0]; cs2 = v.c2[1:0]; memAlu = v.alu; memRead = v.rdat;
    exRd = v.erd[4:0]; exWe = v.ewe[0];
  endtask

  task automatic applyIdle();
    idValid = 0; isBr = 0; isJal = 0; isJalr = 0; funct3 = 0; idPc = 0; idImm = 0;
    rs1 = 0; rs2 = 0; rf1 = 0; rf2 = 0; cs1 = 0; cs2 = 0; memAlu = 0; memRead = 0;
    exRd = 0; exWe = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkCounts(input string name);
    checkOutput({name, " branch_count"}, 32'(branchCount), 32'(expBc));
    checkOutput({name, " taken_count"}, 32'(takenCount), 32'(expTc));
  endtask

  // BEQ x4,x6 with EX writing x4: the canonical hazard instruction
  task automatic applyHazardBeq(input logic we, input logic [1:0] c1);
    applyIdle();
    idValid = 1; isBr = 1; funct3 = 3'b000; idPc = 32'h800; idImm = 32'h10;
    rs1 = 4; rs2 = 6; rf1 = 0; rf2 = 32'h10; memAlu = 32'h10; cs1 = c1;
    exRd = 4; exWe = we;
  endtask

  initial begin
    // valid br jal jalr f3 pc imm r1 r2 d1 d2 c1 c2 alu rdat erd ewe | stall taken pc bc tc
    vecs[0]  = '{1,1,0,0,0,32'h100,32'h20,5,6,32'h10,32'h10,0,0,0,0,0,0, 0,1,32'h120,1,1};
    vecs[1]  = '{1,1,0,0,4,32'h200,32'h10,5,6,32'hFFFFFFFF,1,0,0,0,0,0,0, 0,1,32'h210,2,2};
    vecs[2]  = '{1,1,0,0,6,32'h200,32'h10,5,6,32'hFFFFFFFF,1,0,0,0,0,0,0, 0,0,0,3,2};
    vecs[3]  = '{1,1,0,0,1,32'h300,32'h8,3,6,0,0,2,0,7,0,0,0, 0,1,32'h308,4,3};
    vecs[4]  = '{1,1,0,0,1,32'h300,32'h8,3,6,0,0,1,0,7,0,0,0, 0,0,0,5,3};
    vecs[5]  = '{1,0,0,1,0,32'h600,32'h41,0,0,32'h55,0,0,0,0,0,0,1, 0,1,32'h40,6,4};
    vecs[6]  = '{1,0,1,0,0,32'h1000,32'hFFFFFFF0,5,5,0,0,0,0,0,0,5,1, 0,1,32'hFF0,7,5};
    vecs[7]  = '{1,1,0,0,5,32'h200,32'h10,5,6,32'h80000000,0,0,0,0,0,0,0, 0,0,0,8,5};
    vecs[8]  = '{1,1,0,0,7,32'hFFFFFFF0,32'h20,5,6,32'h80000000,0,0,0,0,0,0,0, 0,1,32'h10,9,6};
    vecs[9]  = '{1,1,0,0,2,32'h200,32'h10,5,6,5,5,0,0,0,0,0,0, 0,0,0,10,6};
    vecs[10] = '{1,0,0,1,0,32'h200,32'h3,7,8,32'h1000,0,0,0,0,0,8,1, 0,1,32'h1002,11,7};
    vecs[11] = '{0,1,0,0,0,32'h200,32'h10,5,6,5,5,0,0,0,0,5,1, 0,0,0,11,7};
    vecs[12] = '{1,1,0,0,0,32'h400,32'h4,0,0,9,3,2,1,5,6,0,0, 0,1,32'h404,12,8};
    vecs[13] = '{1,1,0,0,0,32'h500,32'h10,1,2,9,9,3,3,5,6,0,0, 0,1,32'h510,13,9};
    vecs[14] = '{1,1,0,0,1,32'h700,32'h40,1,4,1,2,0,0,0,0,4,1, 1,0,0,13,9};
    vecs[15] = '{1,1,0,0,1,32'h700,32'h40,1,4,1,2,0,0,0,0,4,0, 0,1,32'h740,14,10};
    vecs[16] = '{1,0,0,1,0,32'h700,32'h40,4,9,1,2,0,0,0,0,4,1, 1,0,0,14,10};

    // Reset state
    rst = 1'b1;
    applyIdle();
    @(posedge clk); #1;
    checkOutput("reset redirect_valid", 32'(redirectValid), 0);
    checkOutput("reset flush_if_id", 32'(flushIfId), 0);
    checkOutput("reset redirect_pc", redirectPc, 0);
    checkOutput("reset hazard_timeout", 32'(hazardTimeout), 0);
    checkCounts("reset");
    rst = 1'b0;

    // Table: each vector gets one cycle, then an idle cycle covering FLUSH
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d stall", i), 32'(stall), vecs[i].eStall);
      @(posedge clk); #1;
      expBc = int'(vecs[i].eBc);
      expTc = int'(vecs[i].eTc);
      checkOutput($sformatf("v%0d redirect_valid", i), 32'(redirectValid), vecs[i].eTaken);
      checkOutput($sformatf("v%0d flush_if_id", i), 32'(flushIfId), vecs[i].eTaken);
      if (vecs[i].eTaken != 0)
        checkOutput($sformatf("v%0d redirect_pc", i), redirectPc, vecs[i].ePc);
      checkCounts($sformatf("v%0d", i));
      applyIdle();
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d post redirect_valid", i), 32'(redirectValid), 0);
      checkOutput($sformatf("v%0d post flush_if_id", i), 32'(flushIfId), 0);
    end
    checkOutput("table hazard_timeout", 32'(hazardTimeout), 0);

    // Stall one cycle, then resolve via MEM ALU forwarding; counted once
    applyHazardBeq(1'b1, 2'b00);
    #1;
    checkOutput("seqA stall", 32'(stall), 1);
    @(posedge clk); #1;
    checkOutput("seqA stalled redirect_valid", 32'(redirectValid), 0);
    checkCounts("seqA stalled");
    applyHazardBeq(1'b0, 2'b10);
    #1;
    checkOutput("seqA resolve stall", 32'(stall), 0);
    @(posedge clk); #1;
    expBc++; expTc++;
    checkOutput("seqA redirect_valid", 32'(redirectValid), 1);
    checkOutput("seqA redirect_pc", redirectPc, 32'h810);
    checkCounts("seqA");
    // Same instruction still presented during FLUSH: must be ignored
    #1;
    checkOutput("seqA flush stall", 32'(stall), 0);
    @(posedge clk); #1;
    checkOutput("seqA flush redirect_valid", 32'(redirectValid), 0);
    checkCounts("seqA flush");
    applyIdle();
    @(posedge clk); #1;

    // Hazard held four cycles: timeout sets on the fourth and stays set
    applyHazardBeq(1'b1, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("seqB cycle%0d hazard_timeout", c), 32'(hazardTimeout), (c == 4) ? 1 : 0);
    end
    checkCounts("seqB");
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("seqB sticky hazard_timeout", 32'(hazardTimeout), 1);

    // Reset asserted while in FLUSH
    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    checkOutput("seqC pre redirect_valid", 32'(redirectValid), 1);
    rst = 1'b1;
    applyHazardBeq(1'b1, 2'b00);
    #1;
    checkOutput("seqC rst redirect_valid", 32'(redirectValid), 0);
    checkOutput("seqC rst flush_if_id", 32'(flushIfId), 0);
    checkOutput("seqC rst redirect_pc", redirectPc, 0);
    checkOutput("seqC rst hazard_timeout", 32'(hazardTimeout), 0);
    checkOutput("seqC rst stall", 32'(stall), 0);
    expBc = 0; expTc = 0;
    checkCounts("seqC rst");
    #1;
    rst = 1'b0;
    // Back in RUN: a taken branch resolves immediately
    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    expBc = 1; expTc = 1;
    checkOutput("seqC post redirect_valid", 32'(redirectValid), 1);
    checkOutput("seqC post redirect_pc", redirectPc, 32'h120);
    checkCounts("seqC post");
    applyIdle();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
